// File: rtl/rs_param_delay_line.sv
// Runtime-programmable symbol delay line for the RS decoder datapath.
// Each {valid, symbol} word reappears D enabled cycles after capture; output is masked until primed.
`timescale 1ns/1ps
module rs_param_delay_line #(
   parameter int DATA_W        = 7,
   parameter int MAX_DELAY     = 143,
   parameter int ADDR_W        = 8,
   parameter int DEFAULT_DELAY = 143
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              enable,
   input  logic              load,
   input  logic [ADDR_W-1:0] delaySel,
   input  logic [DATA_W-1:0] dataIn,
   input  logic              validIn,
   output logic [DATA_W-1:0] dataOut,
   output logic              validOut,
   output logic              primed,
   output logic [ADDR_W-1:0] curDelay,
   output logic              cfgErr
);

   localparam logic [ADDR_W-1:0] MAX_D   = ADDR_W'(MAX_DELAY);
   localparam logic [ADDR_W-1:0] DEF_D   = ADDR_W'(DEFAULT_DELAY);
   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] TWO     = ADDR_W'(2);

   logic [DATA_W:0]   mem [MAX_DELAY];
   logic [DATA_W:0]   rd_word_reg;
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [ADDR_W-1:0] fill_cnt_reg;
   logic [ADDR_W-1:0] cur_delay_reg;
   logic              primed_reg;
   logic              cfg_err_reg;

   logic              sel_ok;
   logic              flush;
   logic              advance;
   logic [ADDR_W-1:0] last_idx;

   assign sel_ok   = (delaySel >= TWO) && (delaySel <= MAX_D);
   assign flush    = load && sel_ok;
   // A rejected load leaves the stream running, so enable still advances on that cycle.
   assign advance  = enable && !flush;
   assign last_idx = cur_delay_reg - ONE;

   always_ff @(posedge CLK) begin
      if (advance) begin
         mem[wr_ptr_reg] <= {validIn, dataIn};
         rd_word_reg     <= mem[rd_ptr_reg];
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= ONE;
         fill_cnt_reg  <= '0;
         cur_delay_reg <= DEF_D;
         primed_reg    <= 1'b0;
         cfg_err_reg   <= 1'b0;
      end else begin
         cfg_err_reg <= load && !sel_ok;
         if (flush) begin
            cur_delay_reg <= delaySel;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= ONE;
            fill_cnt_reg  <= '0;
            primed_reg    <= 1'b0;
         end else if (advance) begin
            wr_ptr_reg <= (wr_ptr_reg == last_idx) ? '0 : wr_ptr_reg + ONE;
            rd_ptr_reg <= (rd_ptr_reg == last_idx) ? '0 : rd_ptr_reg + ONE;
            if (fill_cnt_reg != last_idx) begin
               fill_cnt_reg <= fill_cnt_reg + ONE;
            end
            // The read issued on this edge is the first one holding a real sample.
            if (fill_cnt_reg == last_idx) begin
               primed_reg <= 1'b1;
            end
         end
      end
   end

   assign dataOut  = primed_reg ? rd_word_reg[DATA_W-1:0] : '0;
   assign validOut = primed_reg & rd_word_reg[DATA_W];
   assign primed   = primed_reg;
   assign curDelay = cur_delay_reg;
   assign cfgErr   = cfg_err_reg;

endmodule

// File: tb/tb_rs_param_delay_line.sv
// Scoreboard bench for rs_param_delay_line: a reference queue of captured words yields the expected outputs.
`timescale 1ns/1ps
module tb_rs_param_delay_line;
   localparam int DW   = 7;
   localparam int AW   = 8;
   localparam int MAXD = 143;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          enable = 1'b0;
   logic          load = 1'b0;
   logic [AW-1:0] delaySel = '0;
   logic [DW-1:0] dataIn = '0;
   logic          validIn = 1'b0;
   logic [DW-1:0] dataOut;
   logic          validOut;
   logic          primed;
   logic [AW-1:0] curDelay;
   logic          cfgErr;

   rs_param_delay_line #(.DATA_W(DW), .MAX_DELAY(MAXD), .ADDR_W(AW), .DEFAULT_DELAY(MAXD)) dut (
      .CLK(CLK), .RESET(RESET), .enable(enable), .load(load), .delaySel(delaySel),
      .dataIn(dataIn), .validIn(validIn), .dataOut(dataOut), .validOut(validOut),
      .primed(primed), .curDelay(curDelay), .cfgErr(cfgErr)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int ramp = 0;

   logic [DW:0]   pipe [$];
   logic [DW:0]   popped;
   logic [DW-1:0] exp_data;
   logic          exp_valid;
   logic          exp_primed;
   logic          exp_cfgerr;
   logic [AW-1:0] exp_delay;

   task automatic model_reset();
      pipe.delete();
      exp_data = '0; exp_valid = 1'b0; exp_primed = 1'b0; exp_cfgerr = 1'b0;
      exp_delay = AW'(MAXD);
   endtask

   // Drives one clock of stimulus and advances the reference model; callers compare.
   task automatic step(input logic en, input logic ld, input logic [AW-1:0] sel,
                       input logic [DW-1:0] din, input logic vin);
      enable = en; load = ld; delaySel = sel; dataIn = din; validIn = vin;
      @(posedge CLK);
      #1;
      exp_cfgerr = 1'b0;
      if (ld && sel >= 2 && sel <= MAXD) begin
         exp_delay = sel;
         pipe.delete();
         exp_data = '0; exp_valid = 1'b0; exp_primed = 1'b0;
      end else begin
         exp_cfgerr = ld;
         if (en) begin
            pipe.push_back({vin, din});
            if (pipe.size() == int'(exp_delay)) begin
               popped     = pipe.pop_front();
               exp_primed = 1'b1;
               exp_data   = popped[DW-1:0];
               exp_valid  = popped[DW];
            end
         end
      end
   endtask

   task automatic next_ramp(output logic [DW-1:0] d);
      d = DW'(ramp % 128);
      ramp++;
   endtask

   task automatic test_reset();
      logic [DW-1:0] d;
      model_reset();
      RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if ({dataOut, validOut, primed, curDelay, cfgErr} !== {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr}) begin
         failures++;
         $display("FAIL reset got=%h want=%h", {dataOut, validOut, primed, curDelay, cfgErr},
                  {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr});
      end
      RESET = 1'b1;
      d = '0;
      $display("reset: outputs cleared, curDelay=%0d", curDelay);
   endtask

   task automatic test_default();
      logic [DW-1:0] d;
      ramp = 0;
      for (int n = 0; n < 160; n++) begin
         next_ramp(d);
         step(1'b1, 1'b0, '0, d, 1'b1);
         checks++;
         if ({dataOut, validOut, primed, curDelay, cfgErr} !== {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr}) begin
            failures++;
            $display("FAIL default n=%0d got=%h want=%h", n, {dataOut, validOut, primed, curDelay, cfgErr},
                     {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr});
         end
      end
      $display("default: 160 enables, D=%0d primed=%b", curDelay, primed);
   endtask

   task automatic test_small_delay();
      logic [DW-1:0] d;
      step(1'b1, 1'b1, AW'(4), 7'h7f, 1'b1);
      for (int n = 0; n < 13; n++) begin
         if (n > 0) begin
            next_ramp(d);
            step(1'b1, 1'b0, '0, d, 1'($urandom_range(0, 1)));
         end
         checks++;
         if ({dataOut, validOut, primed, curDelay, cfgErr} !== {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr}) begin
            failures++;
            $display("FAIL small_delay n=%0d got=%h want=%h", n, {dataOut, validOut, primed, curDelay, cfgErr},
                     {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr});
         end
      end
      $display("small_delay: D=%0d dataOut=%0d", curDelay, dataOut);
   endtask

   task automatic test_enable_gaps();
      logic [DW-1:0] d;
      for (int n = 0; n < 24; n++) begin
         next_ramp(d);
         step(1'((n % 4 == 0) || (n % 4 == 3)), 1'b0, '0, d, 1'($urandom_range(0, 1)));
         checks++;
         if ({dataOut, validOut, primed, curDelay, cfgErr} !== {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr}) begin
            failures++;
            $display("FAIL enable_gaps n=%0d got=%h want=%h", n, {dataOut, validOut, primed, curDelay, cfgErr},
                     {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr});
         end
      end
      $display("enable_gaps: 24 cycles with 1,0,0,1 enable pattern");
   endtask

   task automatic test_cfg_err();
      logic [DW-1:0] d;
      logic [AW-1:0] bad [3];
      bad[0] = AW'(1); bad[1] = AW'(0); bad[2] = AW'(MAXD + 1);
      for (int k = 0; k < 3; k++) begin
         for (int p = 0; p < 2; p++) begin
            next_ramp(d);
            step(1'b1, 1'(p == 0), bad[k], d, 1'b1);
            checks++;
            if ({dataOut, validOut, primed, curDelay, cfgErr} !== {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr}) begin
               failures++;
               $display("FAIL cfg_err sel=%0d p=%0d got=%h want=%h", bad[k], p, {dataOut, validOut, primed, curDelay, cfgErr},
                        {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr});
            end
         end
         $display("cfg_err: rejected delaySel=%0d curDelay=%0d", bad[k], curDelay);
      end
   endtask

   task automatic test_reload();
      logic [DW-1:0] d;
      for (int n = 0; n < 18; n++) begin
         next_ramp(d);
         if (n == 0)       step(1'b1, 1'b1, AW'(5), d, 1'b1);
         else if (n == 11) step(1'b1, 1'b1, AW'(2), 7'h55, 1'b1);
         else              step(1'b1, 1'b0, '0, d, 1'b1);
         checks++;
         if ({dataOut, validOut, primed, curDelay, cfgErr} !== {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr}) begin
            failures++;
            $display("FAIL reload n=%0d got=%h want=%h", n, {dataOut, validOut, primed, curDelay, cfgErr},
                     {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr});
         end
      end
      $display("reload: D=5 then D=2, dataOut=%0d", dataOut);
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d;
      for (int n = 0; n < 11; n++) begin
         next_ramp(d);
         step(1'b1, 1'(n < 3), AW'(3), d, 1'($urandom_range(0, 1)));
         checks++;
         if ({dataOut, validOut, primed, curDelay, cfgErr} !== {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr}) begin
            failures++;
            $display("FAIL back_to_back n=%0d got=%h want=%h", n, {dataOut, validOut, primed, curDelay, cfgErr},
                     {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr});
         end
      end
      $display("back_to_back: load held 3 cycles, D=%0d", curDelay);
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d;
      step(1'b1, 1'b1, AW'(10), 7'h01, 1'b1);
      for (int n = 0; n < 15; n++) begin
         next_ramp(d);
         step(1'b1, 1'b0, '0, d, 1'b1);
      end
      checks++;
      if (primed !== 1'b1 || curDelay !== AW'(10)) begin
         failures++;
         $display("FAIL reset_mid_pre got=%b/%0d want=1/10", primed, curDelay);
      end
      enable = 1'b0; load = 1'b0;
      #2 RESET = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({dataOut, validOut, primed, curDelay, cfgErr} !== {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr}) begin
         failures++;
         $display("FAIL reset_mid_async got=%h want=%h", {dataOut, validOut, primed, curDelay, cfgErr},
                  {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr});
      end
      @(posedge CLK);
      #1 RESET = 1'b1;
      for (int n = 0; n < 150; n++) begin
         next_ramp(d);
         step(1'b1, 1'b0, '0, d, 1'($urandom_range(0, 1)));
         checks++;
         if ({dataOut, validOut, primed, curDelay, cfgErr} !== {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr}) begin
            failures++;
            $display("FAIL reset_mid n=%0d got=%h want=%h", n, {dataOut, validOut, primed, curDelay, cfgErr},
                     {exp_data, exp_valid, exp_primed, exp_delay, exp_cfgerr});
         end
      end
      $display("reset_mid: after reset D=%0d primed=%b", curDelay, primed);
   endtask

   initial begin
      test_reset();
      test_default();
      test_small_delay();
      test_enable_gaps();
      test_cfg_err();
      test_reload();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rs_param_delay_line.md
Name: rs_param_delay_line

Overview:
- Parametrised, runtime-programmable delay buffer for the Reed-Solomon decoder datapath.
- Holds received symbols, plus a per-symbol valid tag, while syndrome, key-equation and Chien/Forney stages compute.
- Presents each symbol again exactly D enabled cycles after capture. D is set per codeword length and is reprogrammable without rebuilding the design.
- Built on an inferred simple dual-port RAM with registered read; adds flush/load, fill tracking and configuration-error flagging.

Parameters:
- DATA_W, 7, symbol width in bits.
- MAX_DELAY, 143, largest supported delay D (RAM depth).
- ADDR_W, 8, pointer/delay field width; must satisfy 2^ADDR_W >= MAX_DELAY + 1.
- DEFAULT_DELAY, 143, delay D in force after reset; must be in [2, MAX_DELAY].

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- enable  in  1  advance strobe; all pointer, RAM and output updates occur only when high (except load).
- load  in  1  one-cycle strobe: apply delaySel and flush.
- delaySel  in  ADDR_W  requested delay D, sampled only when load=1.
- dataIn  in  DATA_W  symbol written on enable.
- validIn  in  1  valid tag stored alongside dataIn.
- dataOut  out  DATA_W  delayed symbol (registered).
- validOut  out  1  delayed valid tag, masked by primed.
- primed  out  1  high once the buffer holds D real entries since last reset/load.
- curDelay  out  ADDR_W  delay D currently in force.
- cfgErr  out  1  one-cycle pulse: rejected delaySel.

Behaviour:
- Reset (asynchronous, RESET=0) sets the following; RAM contents are not cleared, only masked:
  - wrPtr=0, rdPtr=1, fillCnt=0.
  - curDelay=DEFAULT_DELAY.
  - dataOut=0, validOut=0, primed=0, cfgErr=0.
- Storage: RAM word = {validIn, dataIn}, MAX_DELAY deep. Write and registered read both occur on an enable cycle.
- Pointers:
  - wrPtr counts 0..D-1 and wraps to 0.
  - rdPtr = (wrPtr+1) mod D, maintained as its own wrapping counter.
  - Read and write addresses are never equal for D>=2, so no read-during-write hazard.
- Latency contract: index enable cycles from 0 after reset/load. After the edge of enable cycle n (n >= D-1), dataOut/validOut equal dataIn/validIn sampled on enable cycle n-(D-1).
  - Each symbol therefore appears D-1 enables after capture and is held until the next enable, giving D enables of total residence.
- enable=0: all state holds, including dataOut, validOut, primed and pointers.
- Fill:
  - fillCnt increments on each enable, saturating at D-1.
  - primed rises on the edge of enable cycle D-1, coincident with the first genuine output.
  - While primed=0: dataOut forced 0 and validOut forced 0 (stale RAM never leaks).
- Load (takes priority over enable in the same cycle; that cycle's dataIn is NOT written):
  - If 2 <= delaySel <= MAX_DELAY:
    - curDelay <= delaySel.
    - wrPtr <= 0, rdPtr <= 1 (rdPtr <= 0 is not a case since D>=2; wrap applies: if D=2 then rdPtr=1).
    - fillCnt <= 0, primed <= 0, dataOut <= 0, validOut <= 0.
  - Otherwise (0, 1, > MAX_DELAY):
    - cfgErr pulses high for exactly one cycle.
    - curDelay, pointers, fill state and outputs are unchanged; the stream continues undisturbed.
  - load held high for several cycles re-flushes every cycle.
- D=2 boundary: pointers alternate 0/1 and 1/0; output is the symbol from the previous enable.
- D=MAX_DELAY: wrPtr wraps MAX_DELAY-1 -> 0; behaviour matches the fixed 143-deep legacy delay timing at default parameters.
- Reset asserted mid-stream: immediate asynchronous return to reset values. Post-reset behaviour is identical to power-up, with D=DEFAULT_DELAY regardless of any prior load.
- cfgErr is a registered output; it is 0 on every cycle other than the one following a rejected load.

Test Plan:
- Default D=143, enable always high, dataIn = ramp 0..127 repeating, validIn=1 -> primed rises after enable 142; dataOut after enable n equals ramp[n-142]; validOut=0 and dataOut=0 for n<142.
- load with delaySel=4, then ramp -> curDelay=4; primed after 4th enable; dataOut after enable 3 = first sample, then tracks input 3 enables late; wrPtr sequence 0,1,2,3,0.
- enable toggled 1,0,0,1 pattern with D=4 -> outputs and pointers frozen on enable=0 cycles; symbol order and 3-enable latency preserved.
- load with delaySel=1, then 0, then 144 mid-stream -> cfgErr one-cycle pulse each time; curDelay stays 4; data stream continues without glitch.
- D=5 stream running and primed, then load delaySel=2 with enable=1 -> that cycle's dataIn dropped; validOut=0 next cycle; primed after 2nd enable; dataOut = previous-enable sample.
- D=10 primed, RESET pulsed low mid-stream -> all outputs 0 immediately; curDelay=143; primed returns only after 143 enables.
